// File: rtl/spmv_pkg.sv
// rtl/spmv_pkg.sv - shared widths, flag word and host FSM states for the SpMV host interface
package spmv_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 256;
  localparam logic [ADDR_W-1:0] FLAG_ADDR = '0;
  localparam int unsigned TIMEOUT_CYC_DEF = 4096;
  localparam logic [DATA_W-1:0] FLAG_WORD = {{(DATA_W-32){1'b0}}, 32'd1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLAG  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FIN   = 3'd5
  } host_state_e;

endpackage

// File: rtl/spmv_rd_stage.sv
// rtl/spmv_rd_stage.sv - one-outstanding SRAM B read with an output holding register
module spmv_rd_stage
  import spmv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_clear,
  input  logic              i_issue,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_read_data,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_handshake
);

  logic [ADDR_W-1:0] address_q, address_d;
  logic              pend_q, pend_d;
  logic              capt_q, capt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign o_handshake = valid_q & i_out_ready;
  assign o_address   = address_q;
  assign o_out_valid = valid_q;
  assign o_out_data  = data_q;

  // pend: address on the bus this cycle; capt: SRAM data present this cycle
  always_comb begin
    address_d = address_q;
    pend_d    = 1'b0;
    capt_d    = pend_q;
    valid_d   = valid_q;
    data_d    = data_q;
    if (capt_q) begin
      valid_d = 1'b1;
      data_d  = i_read_data;
    end
    if (o_handshake) begin
      valid_d = 1'b0;
    end
    if (i_issue) begin
      address_d = i_addr;
      pend_d    = 1'b1;
    end
    if (i_clear) begin
      address_d = '0;
      pend_d    = 1'b0;
      capt_d    = 1'b0;
      valid_d   = 1'b0;
      data_d    = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      address_q <= '0;
      pend_q    <= 1'b0;
      capt_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      address_q <= address_d;
      pend_q    <= pend_d;
      capt_q    <= capt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: rtl/spmv_host_if.sv
// rtl/spmv_host_if.sv - host loader, start-flag writer and result drainer around the SpMV controller
module spmv_host_if
  import spmv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cfg_start,
  input  logic [ADDR_W-1:0] i_cfg_num_words,
  input  logic [ADDR_W-1:0] i_cfg_num_results,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic [ADDR_W-1:0] o_address_A,
  output logic              o_wr_en_A,
  output logic [DATA_W-1:0] o_write_data_A,
  output logic [ADDR_W-1:0] o_address_B,
  input  logic [DATA_W-1:0] i_read_data_B,
  input  logic              i_ctrl_done,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  input  logic              i_out_ready,
  output logic              o_host_owns,
  output logic [2:0]        o_state,
  output logic              o_done,
  output logic              o_error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  host_state_e       state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] r_q, r_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic [31:0]       tmr_q, tmr_d;
  logic              error_q, error_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [DATA_W-1:0] wdata_a_q, wdata_a_d;
  logic              host_owns_q, host_owns_d;
  logic              done_q, done_d;

  logic              accept;
  logic [CNT_W-1:0]  load_cnt_nx;
  logic [CNT_W-1:0]  rcnt_nx;
  logic              rd_issue;
  logic              rd_clear;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hs;

  assign o_in_ready     = in_ready_q;
  assign o_wr_en_A      = wr_en_q;
  assign o_address_A    = addr_a_q;
  assign o_write_data_A = wdata_a_q;
  assign o_host_owns    = host_owns_q;
  assign o_state        = state_q;
  assign o_done         = done_q;
  assign o_error        = error_q;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    tmr_d       = '0;
    error_d     = error_q;
    in_ready_d  = 1'b0;
    wr_en_d     = 1'b0;
    addr_a_d    = '0;
    wdata_a_d   = '0;
    rd_issue    = 1'b0;
    rd_addr     = '0;
    accept      = i_in_valid & in_ready_q;
    load_cnt_nx = {1'b0, cnt_q} + {{ADDR_W{1'b0}}, accept};
    rcnt_nx     = {1'b0, rcnt_q} + CNT_ONE;

    unique case (state_q)
      ST_IDLE: begin
        if (i_cfg_start) begin
          n_d     = i_cfg_num_words;
          r_d     = i_cfg_num_results;
          cnt_d   = '0;
          rcnt_d  = '0;
          error_d = 1'b0;
          if (i_cfg_num_words != '0) begin
            state_d    = ST_LOAD;
            in_ready_d = 1'b1;
          end else begin
            state_d = ST_FLAG;
          end
        end
      end
      ST_LOAD: begin
        cnt_d      = load_cnt_nx[ADDR_W-1:0];
        in_ready_d = (load_cnt_nx < {1'b0, n_q});
        if (accept) begin
          wr_en_d   = 1'b1;
          addr_a_d  = cnt_q + ADDR_ONE;
          wdata_a_d = i_in_data;
        end
        // all beats were accepted earlier, so this cycle carries the last write
        if (cnt_q == n_q) begin
          state_d = ST_FLAG;
        end
      end
      ST_FLAG: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_d = tmr_q + 32'd1;
        if (i_ctrl_done) begin
          if (r_q != '0) begin
            state_d  = ST_DRAIN;
            rd_issue = 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end else if ((TIMEOUT_CYC != 0) && (tmr_d == TIMEOUT_CYC)) begin
          error_d = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_DRAIN: begin
        if (rd_hs) begin
          rcnt_d = rcnt_nx[ADDR_W-1:0];
          if (rcnt_nx == {1'b0, r_q}) begin
            state_d = ST_FIN;
          end else begin
            rd_issue = 1'b1;
            rd_addr  = rcnt_nx[ADDR_W-1:0];
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // the flag write is registered, so it is scheduled on entry into FLAG
    if (state_d == ST_FLAG) begin
      wr_en_d   = 1'b1;
      addr_a_d  = FLAG_ADDR;
      wdata_a_d = FLAG_WORD;
    end
    host_owns_d = state_d inside {ST_LOAD, ST_FLAG, ST_DRAIN};
    done_d      = (state_d == ST_FIN);
    rd_clear    = (state_d != ST_DRAIN);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      tmr_q       <= '0;
      error_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_a_q    <= '0;
      wdata_a_q   <= '0;
      host_owns_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      tmr_q       <= tmr_d;
      error_q     <= error_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      addr_a_q    <= addr_a_d;
      wdata_a_q   <= wdata_a_d;
      host_owns_q <= host_owns_d;
      done_q      <= done_d;
    end
  end

  spmv_rd_stage u_rd_stage (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_clear     (rd_clear),
    .i_issue     (rd_issue),
    .i_addr      (rd_addr),
    .i_read_data (i_read_data_B),
    .i_out_ready (i_out_ready),
    .o_address   (o_address_B),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .o_handshake (rd_hs)
  );

endmodule

// File: tb/tb_spmv_host_if.sv
// tb/tb_spmv_host_if.sv - randomized self-checking bench for spmv_host_if
module tb_spmv_host_if;

  localparam int AW = 5;
  localparam int DW = 256;
  localparam int TO = 16;
  localparam logic [DW-1:0] FLAG = {{(DW-32){1'b0}}, 32'd1};

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_cfg_start;
  logic [AW-1:0] i_cfg_num_words;
  logic [AW-1:0] i_cfg_num_results;
  logic          i_in_valid;
  logic [DW-1:0] i_in_data;
  logic          o_in_ready;
  logic [AW-1:0] o_address_A;
  logic          o_wr_en_A;
  logic [DW-1:0] o_write_data_A;
  logic [AW-1:0] o_address_B;
  logic [DW-1:0] i_read_data_B;
  logic          i_ctrl_done;
  logic          o_out_valid;
  logic [DW-1:0] o_out_data;
  logic          i_out_ready;
  logic          o_host_owns;
  logic [2:0]    o_state;
  logic          o_done;
  logic          o_error;

  always #5 i_clk = ~i_clk;

  spmv_host_if #(.TIMEOUT_CYC(TO)) dut (
    .i_clk             (i_clk),
    .i_rstn            (i_rstn),
    .i_cfg_start       (i_cfg_start),
    .i_cfg_num_words   (i_cfg_num_words),
    .i_cfg_num_results (i_cfg_num_results),
    .i_in_valid        (i_in_valid),
    .i_in_data         (i_in_data),
    .o_in_ready        (o_in_ready),
    .o_address_A       (o_address_A),
    .o_wr_en_A         (o_wr_en_A),
    .o_write_data_A    (o_write_data_A),
    .o_address_B       (o_address_B),
    .i_read_data_B     (i_read_data_B),
    .i_ctrl_done       (i_ctrl_done),
    .o_out_valid       (o_out_valid),
    .o_out_data        (o_out_data),
    .i_out_ready       (i_out_ready),
    .o_host_owns       (o_host_owns),
    .o_state           (o_state),
    .o_done            (o_done),
    .o_error           (o_error)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [263:0] got, input logic [263:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_w();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // SRAM B model: one-cycle read latency
  logic [DW-1:0] sram_b [32];
  logic [DW-1:0] sram_a [32];
  always @(posedge i_clk) i_read_data_B <= sram_b[o_address_B];

  bit            mon_en = 0;
  bit            acc_pend;
  logic [AW-1:0] acc_k;
  logic [DW-1:0] acc_data;
  int            wr_cnt, first_wr_cyc, last_wr_cyc, flag_cyc, flag_seen;
  int            exp_j, addr_cyc, wait_cyc, done_cyc, done_cnt;
  logic          prev_valid, prev_ready, prev_hs;
  logic [2:0]    prev_state;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] got_out [$];

  always @(negedge i_clk) begin
    if (mon_en) begin
      if (acc_pend) chk("wr_beat", {o_wr_en_A, o_address_A, o_write_data_A}, {1'b1, acc_k, acc_data});
      acc_pend = i_in_valid && o_in_ready;
      if (acc_pend) begin
        acc_k    = acc_k + 1'b1;
        acc_data = i_in_data;
      end
      if (o_wr_en_A) begin
        wr_cnt++;
        sram_a[o_address_A] = o_write_data_A;
        if (o_address_A == '0) begin
          flag_seen = 1;
          flag_cyc  = cyc;
        end else begin
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
        end
      end
      chk("own", o_host_owns, (o_state == 3'd1) || (o_state == 3'd2) || (o_state == 3'd4));
      if (o_state == 3'd3) chk("wait_quiet", {o_wr_en_A, o_address_A, o_address_B, |o_write_data_A}, 0);
      if (o_state == 3'd3 && prev_state != 3'd3) wait_cyc = cyc;
      if (o_state == 3'd4 && (prev_state != 3'd4 || prev_hs)) begin
        chk("addr_b", o_address_B, exp_j);
        addr_cyc = cyc;
        exp_j++;
      end
      if (o_out_valid && !prev_valid) chk("rd_lat", cyc - addr_cyc, 2);
      if (prev_valid && !prev_ready) chk("hold", {o_out_valid, o_out_data}, {1'b1, prev_data});
      if (prev_hs) chk("drop", o_out_valid, 0);
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("fin_st", o_state, 5);
      end
      prev_hs = o_out_valid && i_out_ready;
      if (prev_hs) got_out.push_back(o_out_data);
      prev_valid = o_out_valid;
      prev_ready = i_out_ready;
      prev_data  = o_out_data;
      prev_state = o_state;
    end
  end

  task automatic clear_run();
    for (int j = 0; j < 32; j++) sram_a[j] = 'x;
    acc_pend = 0; acc_k = '0; wr_cnt = 0; first_wr_cyc = -1; last_wr_cyc = -1;
    flag_cyc = -1; flag_seen = 0; exp_j = 0; done_cnt = 0; wait_cyc = -1; done_cyc = -1;
    got_out.delete();
  endtask

  task automatic run(input int n, input int r, input bit fixed, input bit vrand,
                     input int rmode, input bit tmo, input bit glitch);
    logic [DW-1:0] beats [$];
    int sent, guard, dly, start_cyc;
    beats.delete();
    for (int k = 0; k < n; k++) beats.push_back(fixed ? DW'(32'hA + k) : rand_w());
    for (int j = 0; j < 32; j++) sram_b[j] = fixed ? DW'(32'h100 + j) : rand_w();
    clear_run();
    chk("idle_before", o_state, 0);
    i_cfg_num_words = AW'(n);
    i_cfg_num_results = AW'(r);
    i_cfg_start = 1'b1;
    start_cyc = cyc;
    tick();
    i_cfg_start = 1'b0;
    i_cfg_num_words = AW'($urandom);
    i_cfg_num_results = AW'($urandom);
    chk("err_clr", o_error, 0);

    sent = 0;
    guard = 0;
    while (sent < n && guard < 500) begin
      i_in_valid  = vrand ? 1'($urandom_range(0, 1)) : 1'b1;
      i_in_data   = i_in_valid ? beats[sent] : rand_w();
      i_ctrl_done = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i_in_valid && o_in_ready) sent++;
      tick();
      guard++;
    end
    chk("load_beats", sent, n);
    i_ctrl_done = 1'b0;
    i_in_valid  = 1'b1;
    i_in_data   = rand_w();
    guard = 0;
    while (o_state != 3'd3 && guard < 50) begin
      tick();
      guard++;
    end
    i_in_valid = 1'b0;
    chk("reach_wait", o_state, 3);

    if (glitch) begin
      i_cfg_start = 1'b1;
      i_cfg_num_words = AW'(7);
      tick();
      i_cfg_start = 1'b0;
    end
    if (!tmo) begin
      dly = $urandom_range(0, 8);
      repeat (dly) tick();
      i_ctrl_done = 1'b1;
      tick();
      i_ctrl_done = 1'b0;
    end

    guard = 0;
    while (done_cnt == 0 && guard < 800) begin
      case (rmode)
        0:       i_out_ready = 1'b1;
        1:       i_out_ready = (cyc % 2) == 0;
        default: i_out_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      guard++;
    end
    i_out_ready = 1'b0;
    chk("done_seen", done_cnt > 0, 1);
    repeat (3) tick();
    chk("done_once", done_cnt, 1);
    chk("error", o_error, tmo);
    chk("end_idle", o_state, 0);
    if (tmo) chk("tmo_lat", done_cyc - wait_cyc, TO);
    chk("wr_cnt", wr_cnt, n + 1);
    for (int k = 0; k < n; k++) chk("sram_a", sram_a[k+1], beats[k]);
    chk("flag_word", sram_a[0], FLAG);
    chk("flag_cyc", flag_cyc, (n == 0) ? start_cyc + 1 : last_wr_cyc + 1);
    if (!vrand && n > 0) chk("wr_b2b", last_wr_cyc - first_wr_cyc, n - 1);
    chk("n_out", got_out.size(), tmo ? 0 : r);
    chk("n_addr", exp_j, tmo ? 0 : r);
    for (int j = 0; j < got_out.size() && j < 32; j++) chk("out_data", got_out[j], sram_b[j]);
  endtask

  task automatic reset_mid_load();
    int sent, guard;
    clear_run();
    i_cfg_num_words = AW'(5);
    i_cfg_num_results = AW'(1);
    i_cfg_start = 1'b1;
    tick();
    i_cfg_start = 1'b0;
    sent = 0;
    guard = 0;
    while (sent < 2 && guard < 20) begin
      i_in_valid = 1'b1;
      i_in_data  = rand_w();
      if (o_in_ready) sent++;
      tick();
      guard++;
    end
    chk("rst_pre_beats", sent, 2);
    i_in_valid = 1'b0;
    i_rstn = 1'b0;
    tick();
    chk("rst_mid_ctl", {o_in_ready, o_address_A, o_wr_en_A, o_address_B, o_out_valid,
                        o_host_owns, o_state, o_done, o_error}, 0);
    chk("rst_mid_data", {|o_write_data_A, |o_out_data}, 0);
    tick();
    i_rstn = 1'b1;
    repeat (30) tick();
    chk("rst_no_flag", flag_seen, 0);
    chk("rst_wr_cnt", wr_cnt, 2);
    chk("rst_idle", o_state, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rstn = 1'b0;
    i_cfg_start = 1'b0;
    i_cfg_num_words = '0;
    i_cfg_num_results = '0;
    i_in_valid = 1'b0;
    i_in_data = '0;
    i_ctrl_done = 1'b0;
    i_out_ready = 1'b0;
    for (int j = 0; j < 32; j++) sram_b[j] = '0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_hs = 1'b0; prev_state = '0; prev_data = '0;
    clear_run();
    repeat (3) tick();
    chk("rst_ctl", {o_in_ready, o_address_A, o_wr_en_A, o_address_B, o_out_valid,
                    o_host_owns, o_state, o_done, o_error}, 0);
    chk("rst_data", {|o_write_data_A, |o_out_data}, 0);
    i_rstn = 1'b1;
    tick();
    mon_en = 1;

    run(3, 2, 1, 0, 0, 0, 0);
    run(0, 0, 1, 0, 0, 0, 0);
    run(2, 4, 1, 0, 1, 0, 0);
    run(1, 2, 0, 0, 0, 1, 0);
    run(2, 1, 0, 1, 2, 0, 0);
    reset_mid_load();
    run(4, 3, 0, 1, 2, 0, 1);
    run(31, 31, 0, 1, 2, 0, 0);
    repeat (4) run($urandom_range(0, 31), $urandom_range(0, 31), 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 0, 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spmv_host_if.md
Name: spmv_host_if

Overview:
Host-side front/back end for the SpMV ops controller.
- Before a run: streams operand words from the host into SRAM A, then writes the start flag word that the controller polls at SRAM A address 0.
- During the run: waits for the controller's done pulse.
- After the run: drains result words from SRAM B onto an output stream.
- SRAM ownership: the top-level mux gives this block SRAM A/B access while o_host_owns=1; otherwise the controller owns them.

Parameters:
ADDR_W, 5, SRAM word-address width
DATA_W, 256, SRAM word width
FLAG_ADDR, 0, SRAM A address of the start flag word
TIMEOUT_CYC, 4096, max cycles in WAIT before error abort (0 = no timeout)

Ports:
i_clk  in  1  clock
i_rstn  in  1  synchronous active-low reset
i_cfg_start  in  1  start pulse; sampled only in IDLE
i_cfg_num_words  in  ADDR_W  operand words to load, N (0..31), written to addresses 1..N; sampled on start
i_cfg_num_results  in  ADDR_W  result words to drain, R (0..31), read from addresses 0..R-1; sampled on start
i_in_valid  in  1  operand stream valid
i_in_data  in  DATA_W  operand stream data
o_in_ready  out  1  operand stream ready
o_address_A  out  ADDR_W  SRAM A address
o_wr_en_A  out  1  SRAM A write enable
o_write_data_A  out  DATA_W  SRAM A write data
o_address_B  out  ADDR_W  SRAM B read address
i_read_data_B  in  DATA_W  SRAM B read data, 1-cycle latency
i_ctrl_done  in  1  controller done pulse
o_out_valid  out  1  result stream valid
o_out_data  out  DATA_W  result stream data
i_out_ready  in  1  result stream ready
o_host_owns  out  1  this block owns SRAM A/B ports
o_state  out  3  FSM state encoding
o_done  out  1  one-cycle run-complete pulse
o_error  out  1  sticky timeout flag; cleared by next accepted start

Behaviour:
Reset and outputs
- All outputs registered. Reset value of every output is 0; FSM returns to IDLE.
- Reset mid-run aborts immediately; no partial flag write is completed.

States: IDLE=0, LOAD=1, FLAG=2, WAIT=3, DRAIN=4, FIN=5.

IDLE
- On i_cfg_start: latch N and R, clear o_error.
- Go to LOAD if N>0, else FLAG.

LOAD
- o_host_owns=1; o_in_ready=1 while fewer than N beats accepted.
- A beat accepted at cycle t (valid&ready) produces, at cycle t+1: o_wr_en_A=1, o_address_A=k (k = 1..N in order), o_write_data_A=data.
- o_in_ready drops the cycle after the Nth accept. Go to FLAG after the Nth write cycle.
- Back-to-back accepts give one write per cycle.

FLAG
- Exactly one cycle: o_wr_en_A=1, o_address_A=FLAG_ADDR, o_write_data_A = 1 in bits [31:0], 0 in all other bits.
- Next state: WAIT.

WAIT
- o_host_owns=0; all SRAM outputs 0; timeout counter runs.
- On i_ctrl_done: go to DRAIN if R>0, else FIN.
- If the counter reaches TIMEOUT_CYC: set o_error, go to FIN.
- i_ctrl_done in any other state is ignored.

DRAIN
- o_host_owns=1; o_wr_en_A and o_wr_en_B held 0.
- One outstanding read: address j (0..R-1) driven at cycle c.
- i_read_data_B captured at c+1 into o_out_data, with o_out_valid=1 from c+2.
- o_out_data and o_out_valid hold stable until i_out_ready is seen.
- Handshake at cycle h: o_out_valid drops at h+1 and address j+1 is driven at h+1.
- After the Rth handshake, go to FIN.

FIN
- o_done=1 for exactly one cycle, o_host_owns=0, then IDLE.
- o_done also pulses on the timeout path.

Boundary rules
- i_cfg_start outside IDLE is ignored.
- Address counters never wrap: N and R are at most 31, so the final address is 31.
- In LOAD, i_in_valid with ready=0 does not advance the beat count.

Decomposition:
- Shared package (spmv_pkg): ADDR_W, DATA_W, FLAG_ADDR, FLAG_WORD constant (1 in bits [31:0], 0 elsewhere), host FSM state enum.
- One natural sub-module: spmv_rd_stage, the one-outstanding SRAM read plus output holding register used by DRAIN.

Test Plan:
1. N=3 with words 0xA, 0xB, 0xC, valid held high -> writes addr 1,2,3 on consecutive cycles; flag write addr 0 data 0x1 on the next cycle; o_host_owns=0 in WAIT.
2. N=0, R=0 -> IDLE→FLAG→WAIT; i_ctrl_done → FIN; o_done pulses one cycle; no DRAIN reads.
3. R=4, SRAM B addr i holds 0x100+i, i_out_ready toggling 1/0 -> output sequence 0x100..0x103 in order; data stable while valid && !ready; exactly 4 handshakes, then o_done.
4. TIMEOUT_CYC=16, no i_ctrl_done -> o_error=1 and o_done pulse 16 cycles after entering WAIT; next start clears o_error.
5. Reset asserted mid-LOAD after 2 of 5 beats -> next cycle all outputs 0, state IDLE, no flag write ever issued.
6. i_cfg_start pulsed during WAIT and i_ctrl_done pulsed during LOAD -> both ignored; the run completes normally.
